// File: rtl/khc_onehot_decoder_if.sv
// Tiny Tapeout pin frame for khc_onehot_decoder; clk and rst_n stay plain ports.
// The decoder uses the slave modport, and the board or bench driving it uses the master modport.
interface khc_onehot_decoder_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    modport master (
        output ena, ui_in, uio_in,
        input  uio_out, uio_oe, uo_out
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uio_out, uio_oe, uo_out
    );
endinterface

// File: rtl/khc_onehot_decoder.sv
// Expands priority-encoder codes into a 16-bit one-hot word sent as two byte beats, low byte first.
// Define KHC_ACCUM_EN to OR hold=1 codes into an accumulator that is emitted with the next hold=0 code.
module khc_onehot_decoder (
    input logic                 clk,
    input logic                 rst_n,
    khc_onehot_decoder_if.slave tt
);
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] SEND_LO = 2'b01;
    localparam logic [1:0] SEND_HI = 2'b10;

    logic [1:0]  state;
    logic [7:0]  out_byte;
    logic [7:0]  hi_byte;
    logic        none;
    logic        err;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] dec_bit;
    logic        code_ok;
    logic        code_none;

    assign in_valid  = tt.uio_in[0];
    assign out_ready = tt.uio_in[1];

    always_comb begin
        dec_bit   = '0;
        code_ok   = (tt.ui_in[7:4] == 4'h0);
        code_none = (tt.ui_in == 8'hF0);
        if (code_ok) dec_bit[tt.ui_in[3:0]] = 1'b1;
    end

`ifdef KHC_ACCUM_EN
    logic        hold;
    logic [15:0] acc;
    logic [15:0] merged;
    logic        acc_pure;
    logic        unused_bits;

    assign hold        = tt.uio_in[2];
    assign merged      = acc | dec_bit;
    assign unused_bits = &{tt.ena, tt.uio_in[7:3]};
`else
    logic unused_bits;

    assign unused_bits = &{tt.ena, tt.uio_in[7:2]};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_byte <= '0;
            hi_byte  <= '0;
            none     <= 1'b0;
            err      <= 1'b0;
`ifdef KHC_ACCUM_EN
            acc      <= '0;
            acc_pure <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!code_ok && !code_none) err <= 1'b1;
`ifdef KHC_ACCUM_EN
                        // acc_pure tracks whether every contribution so far was the "no bit" code
                        if (hold) begin
                            acc      <= merged;
                            acc_pure <= acc_pure & code_none;
                        end else begin
                            out_byte <= merged[7:0];
                            hi_byte  <= merged[15:8];
                            none     <= (merged == 16'h0000) && acc_pure && code_none;
                            acc      <= '0;
                            acc_pure <= 1'b1;
                            state    <= SEND_LO;
                        end
`else
                        out_byte <= dec_bit[7:0];
                        hi_byte  <= dec_bit[15:8];
                        none     <= code_none;
                        state    <= SEND_LO;
`endif
                    end
                end
                SEND_LO: begin
                    if (out_ready) begin
                        out_byte <= hi_byte;
                        state    <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (out_ready) begin
                        out_byte <= '0;
                        none     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    out_byte <= '0;
                    none     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign tt.uo_out  = out_byte;
    assign tt.uio_out = {err, none, (state != IDLE), (state == IDLE), 4'h0};
    assign tt.uio_oe  = 8'hF0;
endmodule

// File: tb/tb_khc_onehot_decoder.sv
// Directed and randomized checks of khc_onehot_decoder against a transaction-level model.
// Build with KHC_ACCUM_EN defined to exercise the accumulator steps as well.
module tb_khc_onehot_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic hold = 1'b0;
    logic [4:0] junk = 5'h0;
    logic [7:0] code_in = 8'h00;

    int unsigned compares = 0;
    int unsigned fails = 0;

    // Model state: sticky error, pending accumulated word, and whether every pending code was 0xF0.
    logic        m_err = 1'b0;
    logic [15:0] m_acc = 16'h0000;
    logic        m_pure = 1'b1;

    khc_onehot_decoder_if tt ();

    assign tt.ena    = 1'b1;
    assign tt.ui_in  = code_in;
    assign tt.uio_in = {junk, hold, out_ready, in_valid};

    khc_onehot_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tt    (tt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag, input logic [7:0] e_uo, input logic e_busy,
                          input logic e_none);
        check({tag, ".uo_out"},  {8'h00, tt.uo_out},  {8'h00, e_uo});
        check({tag, ".uio_out"}, {8'h00, tt.uio_out}, {8'h00, m_err, e_none, e_busy, ~e_busy, 4'h0});
        check({tag, ".uio_oe"},  {8'h00, tt.uio_oe},  16'h00F0);
    endtask

    function automatic logic [15:0] onehot(input logic [7:0] code);
        return (code < 8'd16) ? 16'(32'd1 << code) : 16'h0000;
    endfunction

    task automatic junk_inputs();
        in_valid = 1'($urandom);
        code_in  = 8'($urandom);
        junk     = 5'($urandom);
        hold     = 1'($urandom);
    endtask

    // Accepts one code and plays both beats, stalling each beat for the given number of cycles.
    task automatic xfer(input string tag, input logic [7:0] code, input int unsigned st_lo,
                        input int unsigned st_hi);
        logic [15:0] w;
        logic        e_none;
        if (code >= 8'd16 && code != 8'hF0) m_err = 1'b1;
        w      = m_acc | onehot(code);
        e_none = (w == 16'h0000) && m_pure && (code == 8'hF0);
        m_acc  = 16'h0000;
        m_pure = 1'b1;

        code_in   = code;
        in_valid  = 1'b1;
        out_ready = 1'($urandom);
        junk      = 5'($urandom);
`ifdef KHC_ACCUM_EN
        hold = 1'b0;
`else
        hold = 1'($urandom);
`endif
        tick();
        status({tag, ".lo"}, w[7:0], 1'b1, e_none);
        for (int unsigned i = 0; i < st_lo; i++) begin
            junk_inputs();
            out_ready = 1'b0;
            tick();
            status({tag, ".lo_stall"}, w[7:0], 1'b1, e_none);
        end
        junk_inputs();
        out_ready = 1'b1;
        tick();
        status({tag, ".hi"}, w[15:8], 1'b1, e_none);
        for (int unsigned i = 0; i < st_hi; i++) begin
            junk_inputs();
            out_ready = 1'b0;
            tick();
            status({tag, ".hi_stall"}, w[15:8], 1'b1, e_none);
        end
        junk_inputs();
        out_ready = 1'b1;
        tick();
        status({tag, ".idle"}, 8'h00, 1'b0, 1'b0);
        in_valid  = 1'b0;
        hold      = 1'b0;
        out_ready = 1'b0;
    endtask

`ifdef KHC_ACCUM_EN
    task automatic xfer_hold(input string tag, input logic [7:0] code);
        if (code >= 8'd16 && code != 8'hF0) m_err = 1'b1;
        m_acc    = m_acc | onehot(code);
        m_pure   = m_pure && (code == 8'hF0);
        code_in  = code;
        in_valid = 1'b1;
        hold     = 1'b1;
        tick();
        status({tag, ".held"}, 8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        hold     = 1'b0;
    endtask
`endif

    function automatic logic [7:0] rand_code();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 6) return 8'($urandom_range(0, 15));
        if (r < 8) return 8'hF0;
        return 8'($urandom);
    endfunction

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        status("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        status("post_reset_idle", 8'h00, 1'b0, 1'b0);

        xfer("code03", 8'h03, 0, 0);
        xfer("code0F_stall", 8'h0F, 5, 0);
        xfer("codeF0", 8'hF0, 1, 2);
        xfer("code42", 8'h42, 0, 1);
        xfer("code00_err_sticky", 8'h00, 0, 0);

        // Reset while the high beat is pending.
        code_in   = 8'h05;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        status("pre_reset_hi", 8'h00, 1'b1, 1'b0);
        rst_n     = 1'b0;
        out_ready = 1'b0;
        m_err     = 1'b0;
        m_acc     = 16'h0000;
        m_pure    = 1'b1;
        tick();
        status("mid_reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        xfer("code08", 8'h08, 0, 0);

`ifdef KHC_ACCUM_EN
        xfer_hold("acc01", 8'h01);
        xfer_hold("acc09", 8'h09);
        xfer("acc0C", 8'h0C, 0, 0);
        xfer("acc_cleared", 8'h00, 0, 0);
        xfer_hold("accF0", 8'hF0);
        xfer("accF0_F0", 8'hF0, 0, 0);
`endif

        for (int unsigned n = 0; n < 40; n++) begin
`ifdef KHC_ACCUM_EN
            if ($urandom_range(0, 2) == 0) begin
                xfer_hold("rand_hold", rand_code());
                continue;
            end
`endif
            xfer("rand", rand_code(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
